// File: rtl/stack_unit_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : stack_unit_if                                              |
// | Description : Request/status bundle between the stack CPU control unit   |
// |               and the hardware operand stack.                            |
// |   master : push, pop, din, err_clr driven; tos/nos/count/flags observed  |
// |   slave  : the stack itself (receives requests, drives status)           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface stack_unit_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic             err_clr;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nos;
  logic [PW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, din, err_clr,
    input  tos, nos, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, din, err_clr,
    output tos, nos, count, empty, full, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/stack_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : stack_unit                                                 |
// | Description : Hardware LIFO for the multicycle stack CPU. Accepts push / |
// |               pop requests on the rising edge, exposes top and next-on-  |
// |               stack entries, occupancy and sticky over/underflow flags.  |
// | Ports       : clk  - clock                                               |
// |               rst  - asynchronous reset, active low                      |
// |               bus  - stack_unit_if.slave (push, pop, din, err_clr in;    |
// |                      tos, nos, count, empty, full, overflow, underflow)  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  wire logic      clk,
  input  wire logic      rst,
  stack_unit_if.slave    bus
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int AW = PW - 1;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic             w_empty, w_full;
  logic [AW-1:0]    w_top_idx, w_nos_idx, w_wr_idx;

  assign w_empty   = (state_q == S_EMPTY);
  assign w_full    = (state_q == S_FULL);
  // DEPTH is a power of two, so modulo-DEPTH index arithmetic is exact for
  // every valid entry; out-of-range cases are gated off at the outputs.
  assign w_wr_idx  = count_q[AW-1:0];
  assign w_top_idx = count_q[AW-1:0] - AW'(1);
  assign w_nos_idx = count_q[AW-1:0] - AW'(2);

  always_comb begin
    count_d = count_q;
    mem_d   = mem_q;
    // Clear first so that an error in the same cycle re-sets the flag.
    ovf_d   = ovf_q & ~bus.err_clr;
    unf_d   = unf_q & ~bus.err_clr;

    if (bus.push && bus.pop) begin
      if (w_empty) begin
        // Replace on an empty stack degenerates into a plain push.
        mem_d[w_wr_idx] = bus.din;
        count_d         = PW'(1);
      end else begin
        mem_d[w_top_idx] = bus.din;
      end
    end else if (bus.push) begin
      if (w_full) begin
        ovf_d = 1'b1;
      end else begin
        mem_d[w_wr_idx] = bus.din;
        count_d         = count_q + PW'(1);
      end
    end else if (bus.pop) begin
      if (w_empty) begin
        unf_d = 1'b1;
      end else begin
        count_d = count_q - PW'(1);
      end
    end

    if (count_d == '0) begin
      state_d = S_EMPTY;
    end else if (count_d == PW'(DEPTH)) begin
      state_d = S_FULL;
    end else begin
      state_d = S_PARTIAL;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_EMPTY;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      mem_q   <= mem_d;
    end
  end

  assign bus.tos       = (count_q != '0)        ? mem_q[w_top_idx] : '0;
  assign bus.nos       = (count_q >= PW'(2))    ? mem_q[w_nos_idx] : '0;
  assign bus.count     = count_q;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule
`default_nettype wire

// File: tb/tb_stack_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_stack_unit                                              |
// | Description : Directed-vector bench for stack_unit with a queue-based    |
// |               scoreboard and an independent negedge monitor.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_stack_unit;
  logic clk;
  logic rst;

  typedef struct {
    string      name;
    logic [7:0] tos;
    logic [7:0] nos;
    logic [3:0] count;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int   total;
  int   bad;

  stack_unit_if #(.WIDTH(8), .DEPTH(8)) bus ();

  stack_unit #(.WIDTH(8), .DEPTH(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares the oldest pending expectation against the DUT.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      total++;
      if ({bus.tos, bus.nos, bus.count, bus.empty, bus.full, bus.overflow, bus.underflow} !==
          {cur.tos, cur.nos, cur.count, cur.empty, cur.full, cur.ovf, cur.unf}) begin
        bad++;
        $display("FAIL %s: got tos=%h nos=%h cnt=%0d e=%b f=%b ovf=%b unf=%b, want tos=%h nos=%h cnt=%0d e=%b f=%b ovf=%b unf=%b",
                 cur.name, bus.tos, bus.nos, bus.count, bus.empty, bus.full, bus.overflow, bus.underflow,
                 cur.tos, cur.nos, cur.count, cur.empty, cur.full, cur.ovf, cur.unf);
      end
    end
  end

  function automatic exp_t mk(input string nm, input logic [7:0] t, input logic [7:0] n,
                              input logic [3:0] c, input logic e, input logic f,
                              input logic o, input logic u);
    exp_t x;
    x.name = nm; x.tos = t; x.nos = n; x.count = c;
    x.empty = e; x.full = f; x.ovf = o; x.unf = u;
    return x;
  endfunction

  // One cycle of stimulus; the expected post-edge state goes to the scoreboard.
  task automatic step(input logic p, input logic po, input logic [7:0] d, input logic clr,
                      input exp_t e);
    @(negedge clk);
    bus.push = p; bus.pop = po; bus.din = d; bus.err_clr = clr;
    @(posedge clk);
    #1;
    sb_q.push_back(e);
    bus.push = 1'b0; bus.pop = 1'b0; bus.err_clr = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.din = 8'h00; bus.err_clr = 1'b0;
    #1;
    sb_q.push_back(mk("reset", 8'h00, 8'h00, 4'd0, 1, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;

    step(1, 0, 8'h11, 0, mk("push11", 8'h11, 8'h00, 4'd1, 0, 0, 0, 0));
    step(1, 0, 8'h22, 0, mk("push22", 8'h22, 8'h11, 4'd2, 0, 0, 0, 0));
    step(1, 0, 8'h33, 0, mk("push33", 8'h33, 8'h22, 4'd3, 0, 0, 0, 0));
    step(0, 1, 8'h00, 0, mk("pop1",   8'h22, 8'h11, 4'd2, 0, 0, 0, 0));
    step(0, 1, 8'h00, 0, mk("pop2",   8'h11, 8'h00, 4'd1, 0, 0, 0, 0));
    step(0, 1, 8'h00, 0, mk("pop3",   8'h00, 8'h00, 4'd0, 1, 0, 0, 0));
    step(0, 1, 8'h00, 0, mk("pop_underflow", 8'h00, 8'h00, 4'd0, 1, 0, 0, 1));
    step(0, 0, 8'h00, 1, mk("clr_unf", 8'h00, 8'h00, 4'd0, 1, 0, 0, 0));

    for (int k = 1; k <= 8; k++) begin
      step(1, 0, 8'(k), 0, mk("push_fill", 8'(k), (k > 1) ? 8'(k - 1) : 8'h00, 4'(k),
                               0, (k == 8), 0, 0));
    end
    step(1, 0, 8'hFF, 0, mk("push_overflow", 8'h08, 8'h07, 4'd8, 0, 1, 1, 0));
    step(0, 0, 8'h00, 1, mk("clr_ovf",       8'h08, 8'h07, 4'd8, 0, 1, 0, 0));
    step(1, 1, 8'hEE, 0, mk("replace_full",  8'hEE, 8'h07, 4'd8, 0, 1, 0, 0));

    for (int c = 7; c >= 0; c--) begin
      step(0, 1, 8'h00, 0, mk("pop_drain", 8'(c), (c >= 2) ? 8'(c - 1) : 8'h00, 4'(c),
                              (c == 0), 0, 0, 0));
    end
    step(0, 1, 8'h00, 1, mk("clr_vs_unf_set_wins", 8'h00, 8'h00, 4'd0, 1, 0, 0, 1));
    step(0, 0, 8'h00, 1, mk("clr_unf2",            8'h00, 8'h00, 4'd0, 1, 0, 0, 0));
    step(1, 1, 8'h77, 0, mk("replace_empty", 8'h77, 8'h00, 4'd1, 0, 0, 0, 0));
    step(1, 0, 8'hA0, 0, mk("pushA0",        8'hA0, 8'h77, 4'd2, 0, 0, 0, 0));
    step(1, 1, 8'h5C, 0, mk("replace_mid",   8'h5C, 8'h77, 4'd2, 0, 0, 0, 0));
    step(1, 0, 8'h03, 0, mk("push03",        8'h03, 8'h5C, 4'd3, 0, 0, 0, 0));
    step(1, 0, 8'h04, 0, mk("push04",        8'h04, 8'h03, 4'd4, 0, 0, 0, 0));
    step(1, 0, 8'h05, 0, mk("push05",        8'h05, 8'h04, 4'd5, 0, 0, 0, 0));

    // Reset asserted between edges while a push is held: no edge occurs
    // between assertion and the monitor sample.
    @(negedge clk);
    bus.push = 1'b1; bus.din = 8'h99;
    @(posedge clk);
    #2;
    rst = 1'b0;
    sb_q.push_back(mk("async_reset", 8'h00, 8'h00, 4'd0, 1, 0, 0, 0));
    @(negedge clk);
    #1;
    bus.push = 1'b0;
    rst = 1'b1;
    step(1, 0, 8'h42, 0, mk("push_after_reset", 8'h42, 8'h00, 4'd1, 0, 0, 0, 0));

    for (int w = 0; w < 10 && sb_q.size() > 0; w++) begin
      @(posedge clk);
    end
    if (sb_q.size() > 0) begin
      bad++;
      $display("FAIL drain_timeout: pending=%0d want 0", sb_q.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
